// File: rtl/amux_switch_sequencer.sv
// rtl/amux_switch_sequencer.sv - break-before-make sequencer for pad switches onto AMUXBUS_A/B
// Optional feature macro: AMUX_SEQ_CONFLICT_EN (reject connects whose pad is live on the other bus, pulse err)
module amux_switch_sequencer #(
    parameter int N_PADS     = 8,
    parameter int BBM_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_bus,
    input  logic [$clog2(N_PADS)-1:0] req_pad,
    input  logic                      req_connect,
    output logic [N_PADS-1:0]         amux_a_en,
    output logic [N_PADS-1:0]         amux_b_en,
    output logic                      done
`ifdef AMUX_SEQ_CONFLICT_EN
    ,
    output logic                      err
`endif
);

    // MAKE is never occupied: the make action happens on the edge that leaves GAP.
    typedef enum logic [1:0] {IDLE, GAP, MAKE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic              bus_q, bus_nxt;
    logic [N_PADS-1:0] make_mask, make_mask_nxt;
    logic [N_PADS-1:0] a_nxt, b_nxt;
    logic [N_PADS-1:0] pad_mask;
    logic              ready_nxt, done_nxt;
    logic              conflict;
`ifdef AMUX_SEQ_CONFLICT_EN
    logic              err_nxt;
    logic [N_PADS-1:0] other_en;
`endif

    // Out-of-range pad indices decode to an empty mask, so they break but never make.
    always_comb begin
        pad_mask = '0;
        for (int i = 0; i < N_PADS; i++) begin
            if (32'(req_pad) == i) pad_mask[i] = 1'b1;
        end
    end

`ifdef AMUX_SEQ_CONFLICT_EN
    assign other_en = req_bus ? amux_a_en : amux_b_en;
    assign conflict = req_connect && (|(other_en & pad_mask));
    assign err_nxt  = (state == IDLE) && req_valid && req_ready && conflict;
`else
    assign conflict = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bus_nxt       = bus_q;
        make_mask_nxt = make_mask;
        a_nxt         = amux_a_en;
        b_nxt         = amux_b_en;
        done_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready && !conflict) begin
                    bus_nxt       = req_bus;
                    make_mask_nxt = req_connect ? pad_mask : '0;
                    cnt_nxt       = 8'(BBM_CYCLES - 1);
                    if (req_bus) begin
                        b_nxt = '0;
                        a_nxt = amux_a_en & ~pad_mask;
                    end else begin
                        a_nxt = '0;
                        b_nxt = amux_b_en & ~pad_mask;
                    end
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    // Target vector is all-zero throughout GAP, so the make is a plain load.
                    if (bus_q) b_nxt = make_mask;
                    else       a_nxt = make_mask;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_q     <= 1'b0;
            make_mask <= '0;
            amux_a_en <= '0;
            amux_b_en <= '0;
            req_ready <= 1'b0;
            done      <= 1'b0;
`ifdef AMUX_SEQ_CONFLICT_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bus_q     <= bus_nxt;
            make_mask <= make_mask_nxt;
            amux_a_en <= a_nxt;
            amux_b_en <= b_nxt;
            req_ready <= ready_nxt;
            done      <= done_nxt;
`ifdef AMUX_SEQ_CONFLICT_EN
            err       <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_amux_switch_sequencer.sv
// tb/tb_amux_switch_sequencer.sv - directed self-checking bench for amux_switch_sequencer
module tb_amux_switch_sequencer;

    localparam int N   = 8;
    localparam int BBM = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         req_valid;
    logic         req_ready;
    logic         req_bus;
    logic [2:0]   req_pad;
    logic         req_connect;
    logic [N-1:0] amux_a_en;
    logic [N-1:0] amux_b_en;
    logic         done;
`ifdef AMUX_SEQ_CONFLICT_EN
    logic         err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    amux_switch_sequencer #(.N_PADS(N), .BBM_CYCLES(BBM)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bus     (req_bus),
        .req_pad     (req_pad),
        .req_connect (req_connect),
        .amux_a_en   (amux_a_en),
        .amux_b_en   (amux_b_en),
        .done        (done)
`ifdef AMUX_SEQ_CONFLICT_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with req_ready=1; leaves the bench at the negedge after the done cycle.
    task automatic do_req(input string tag, input logic bus, input logic [2:0] pad, input logic conn,
                          input logic [7:0] ga, input logic [7:0] gb,
                          input logic [7:0] fa, input logic [7:0] fb);
        check({tag, ".ready_T"}, 32'(req_ready), 1);
        req_valid = 1'b1; req_bus = bus; req_pad = pad; req_connect = conn;
        for (int k = 1; k <= BBM; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            check($sformatf("%s.gap_a%0d", tag, k), 32'(amux_a_en), 32'(ga));
            check($sformatf("%s.gap_b%0d", tag, k), 32'(amux_b_en), 32'(gb));
            check($sformatf("%s.gap_done%0d", tag, k), 32'(done), 0);
            check($sformatf("%s.gap_ready%0d", tag, k), 32'(req_ready), 0);
        end
        @(negedge clk);
        check({tag, ".fin_a"}, 32'(amux_a_en), 32'(fa));
        check({tag, ".fin_b"}, 32'(amux_b_en), 32'(fb));
        check({tag, ".fin_done"}, 32'(done), 1);
        check({tag, ".fin_ready"}, 32'(req_ready), 1);
        @(negedge clk);
        check({tag, ".done_clr"}, 32'(done), 0);
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_bus = 1'b0; req_pad = '0; req_connect = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.a", 32'(amux_a_en), 0);
        check("rst.b", 32'(amux_b_en), 0);
        check("rst.done", 32'(done), 0);
        check("rst.ready", 32'(req_ready), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("rst.ready_after", 32'(req_ready), 1);

        do_req("a3",  1'b0, 3'd3, 1'b1, 8'h00, 8'h00, 8'h08, 8'h00);
        do_req("a5",  1'b0, 3'd5, 1'b1, 8'h00, 8'h00, 8'h20, 8'h00);
        do_req("a2",  1'b0, 3'd2, 1'b1, 8'h00, 8'h00, 8'h04, 8'h00);
`ifdef AMUX_SEQ_CONFLICT_EN
        req_valid = 1'b1; req_bus = 1'b1; req_pad = 3'd2; req_connect = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("cf.err", 32'(err), 1);
        check("cf.a", 32'(amux_a_en), 'h04);
        check("cf.b", 32'(amux_b_en), 'h00);
        check("cf.done", 32'(done), 0);
        check("cf.ready", 32'(req_ready), 1);
        @(negedge clk);
        check("cf.err_clr", 32'(err), 0);
        check("cf.done2", 32'(done), 0);
        do_req("a_off", 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        do_req("b2",    1'b1, 3'd2, 1'b1, 8'h00, 8'h00, 8'h00, 8'h04);
`else
        do_req("mv2", 1'b1, 3'd2, 1'b1, 8'h00, 8'h00, 8'h00, 8'h04);
`endif
        do_req("a6",    1'b0, 3'd6, 1'b1, 8'h00, 8'h04, 8'h40, 8'h04);
        do_req("b_off", 1'b1, 3'd0, 1'b0, 8'h40, 8'h00, 8'h40, 8'h00);
`ifdef AMUX_SEQ_CONFLICT_EN
        do_req("a_off6", 1'b0, 3'd6, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
        do_req("b6",     1'b1, 3'd6, 1'b1, 8'h00, 8'h00, 8'h00, 8'h40);
`else
        do_req("mv6", 1'b1, 3'd6, 1'b1, 8'h00, 8'h00, 8'h00, 8'h40);
`endif

        // req_valid held through GAP: second request must wait for req_ready.
        req_valid = 1'b1; req_bus = 1'b1; req_pad = 3'd1; req_connect = 1'b1;
        @(negedge clk);
        req_bus = 1'b0; req_pad = 3'd7;
        for (int k = 1; k <= BBM; k++) begin
            check($sformatf("hold.ready%0d", k), 32'(req_ready), 0);
            check($sformatf("hold.b%0d", k), 32'(amux_b_en), 'h00);
            check($sformatf("hold.a%0d", k), 32'(amux_a_en), 'h00);
            @(negedge clk);
        end
        check("hold.done1", 32'(done), 1);
        check("hold.ready_back", 32'(req_ready), 1);
        check("hold.b_fin", 32'(amux_b_en), 'h02);
        @(negedge clk);
        req_valid = 1'b0;
        check("hold.accept2", 32'(req_ready), 0);
        check("hold.done_clr", 32'(done), 0);
        repeat (BBM - 1) @(negedge clk);
        check("hold.a_gap", 32'(amux_a_en), 'h00);
        @(negedge clk);
        check("hold.a_fin", 32'(amux_a_en), 'h80);
        check("hold.b_keep", 32'(amux_b_en), 'h02);
        check("hold.done2", 32'(done), 1);
        @(negedge clk);

        // Reset asserted two cycles into a connect.
        req_valid = 1'b1; req_bus = 1'b0; req_pad = 3'd4; req_connect = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mrst.a", 32'(amux_a_en), 0);
        check("mrst.b", 32'(amux_b_en), 0);
        check("mrst.ready", 32'(req_ready), 0);
        for (int k = 0; k < BBM + 2; k++) begin
            @(negedge clk);
            check($sformatf("mrst.done%0d", k), 32'(done), 0);
            check($sformatf("mrst.a%0d", k), 32'(amux_a_en), 0);
        end
        resetn = 1'b1;
        @(negedge clk);
        do_req("post", 1'b1, 3'd3, 1'b1, 8'h00, 8'h00, 8'h00, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
